// File: rtl/clock_set_ctrl.sv
// Button-driven hh:mm:ss time-setting controller: snapshot, per-field edit, then commit
// through a held overwrite strobe to the downstream 1 Hz counter.
module clock_set_ctrl #(
    parameter int OW_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [16:0] time_cur,
    output logic [16:0] time_set,
    output logic        time_ow,
    output logic [2:0]  edit_field,
    output logic        busy
);

    typedef enum logic [2:0] {RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;

    localparam int             IW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     OW_LAST   = 8'(OW_CYCLES);

    state_t        state_reg, state_next;
    logic [4:0]    h_reg, h_next;
    logic [5:0]    m_reg, m_next;
    logic [5:0]    s_reg, s_next;
    logic [IW-1:0] idle_reg, idle_next;
    logic [7:0]    ow_cnt_reg, ow_cnt_next;
    logic [16:0]   time_set_reg, time_set_next;
    logic          time_ow_reg, time_ow_next;
    logic [2:0]    edit_field_reg, edit_field_next;
    logic          busy_reg, busy_next;

    logic any_btn, step_up, step_dn;

    // Wrap by explicit compare so no intermediate result grows past the field width.
    function automatic logic [4:0] step_hour(input logic [4:0] v, input logic up, input logic dn);
        if (up)      return (v == 5'd23) ? 5'd0 : v + 5'd1;
        else if (dn) return (v == 5'd0) ? 5'd23 : v - 5'd1;
        else         return v;
    endfunction

    function automatic logic [5:0] step_60(input logic [5:0] v, input logic up, input logic dn);
        if (up)      return (v == 6'd59) ? 6'd0 : v + 6'd1;
        else if (dn) return (v == 6'd0) ? 6'd59 : v - 6'd1;
        else         return v;
    endfunction

    assign any_btn = btn_mode | btn_inc | btn_dec;
    assign step_up = btn_inc & ~btn_dec;
    assign step_dn = btn_dec & ~btn_inc;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_reg      <= RUN;
            h_reg          <= '0;
            m_reg          <= '0;
            s_reg          <= '0;
            idle_reg       <= '0;
            ow_cnt_reg     <= '0;
            time_set_reg   <= '0;
            time_ow_reg    <= 1'b0;
            edit_field_reg <= 3'b000;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            h_reg          <= h_next;
            m_reg          <= m_next;
            s_reg          <= s_next;
            idle_reg       <= idle_next;
            ow_cnt_reg     <= ow_cnt_next;
            time_set_reg   <= time_set_next;
            time_ow_reg    <= time_ow_next;
            edit_field_reg <= edit_field_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        h_next       = h_reg;
        m_next       = m_reg;
        s_next       = s_reg;
        idle_next    = idle_reg;
        ow_cnt_next  = ow_cnt_reg;
        time_ow_next = 1'b0;

        case (state_reg)
            RUN: begin
                if (btn_mode) begin
                    h_next     = (time_cur[16:12] > 5'd23) ? 5'd0 : time_cur[16:12];
                    m_next     = (time_cur[11:6]  > 6'd59) ? 6'd0 : time_cur[11:6];
                    s_next     = (time_cur[5:0]   > 6'd59) ? 6'd0 : time_cur[5:0];
                    idle_next  = '0;
                    state_next = EDIT_H;
                end
            end
            EDIT_H, EDIT_M, EDIT_S: begin
                if (btn_mode) begin
                    idle_next   = '0;
                    ow_cnt_next = '0;
                    case (state_reg)
                        EDIT_H:  state_next = EDIT_M;
                        EDIT_M:  state_next = EDIT_S;
                        default: state_next = COMMIT;
                    endcase
                end else if (any_btn) begin
                    idle_next = '0;
                    case (state_reg)
                        EDIT_H:  h_next = step_hour(h_reg, step_up, step_dn);
                        EDIT_M:  m_next = step_60(m_reg, step_up, step_dn);
                        default: s_next = step_60(s_reg, step_up, step_dn);
                    endcase
                end else if (idle_reg == IDLE_LAST) begin
                    // Abandon the edit silently; no overwrite is issued.
                    idle_next  = '0;
                    state_next = RUN;
                end else begin
                    idle_next = idle_reg + IW'(1);
                end
            end
            COMMIT: begin
                if (ow_cnt_reg < OW_LAST) begin
                    time_ow_next = 1'b1;
                    ow_cnt_next  = ow_cnt_reg + 8'd1;
                end else begin
                    ow_cnt_next = '0;
                    state_next  = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        case (state_next)
            EDIT_H:  edit_field_next = 3'b100;
            EDIT_M:  edit_field_next = 3'b010;
            EDIT_S:  edit_field_next = 3'b001;
            default: edit_field_next = 3'b000;
        endcase
        busy_next     = (state_next != RUN);
        time_set_next = {h_next, m_next, s_next};
    end

    assign time_set   = time_set_reg;
    assign time_ow    = time_ow_reg;
    assign edit_field = edit_field_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: each driven cycle pushes its expected outputs,
// which are popped and compared after the clock edge.
module tb_clock_set_ctrl;

    localparam int OWC = 4;
    localparam int TOC = 16;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        btn_mode, btn_inc, btn_dec;
    logic [16:0] time_cur;
    logic [16:0] time_set;
    logic        time_ow;
    logic [2:0]  edit_field;
    logic        busy;

    typedef struct packed {
        logic [16:0] ts;
        logic        ow;
        logic [2:0]  ef;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   txn         = 0;
    int   eh, em, es;

    clock_set_ctrl #(.OW_CYCLES(OWC), .TIMEOUT_CYCLES(TOC)) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .time_cur   (time_cur),
        .time_set   (time_set),
        .time_ow    (time_ow),
        .edit_field (edit_field),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [16:0] tm(input int h, input int m, input int s);
        return {h[4:0], m[5:0], s[5:0]};
    endfunction

    function automatic exp_t mk(input logic [16:0] ts, input logic ow, input logic [2:0] ef,
                                input logic bz);
        exp_t e;
        e.ts = ts; e.ow = ow; e.ef = ef; e.busy = bz;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, ".sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            txn++;
            $display("txn %0d %s: ts=%05h ow=%b ef=%03b busy=%b", txn, tag,
                     time_set, time_ow, edit_field, busy);
            chk({tag, ".time_set"},   32'(time_set),   32'(e.ts));
            chk({tag, ".time_ow"},    32'(time_ow),    32'(e.ow));
            chk({tag, ".edit_field"}, 32'(edit_field), 32'(e.ef));
            chk({tag, ".busy"},       32'(busy),       32'(e.busy));
        end
    endtask

    // One clock cycle of stimulus; called at 1 time unit after a rising edge.
    task automatic cyc(input logic m, input logic i, input logic d, input exp_t e,
                       input string tag);
        btn_mode = m; btn_inc = i; btn_dec = d;
        sb.push_back(e);
        @(posedge clk_sys);
        #1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        check_out(tag);
    endtask

    initial begin
        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        time_cur = tm(12, 34, 56);
        repeat (3) @(posedge clk_sys);
        #1;
        sb.push_back(mk('0, 1'b0, 3'b000, 1'b0));
        check_out("reset");
        rst = 1'b0;

        cyc(0, 1, 0, mk('0, 0, 3'b000, 0), "run_inc_ignored");
        cyc(0, 0, 1, mk('0, 0, 3'b000, 0), "run_dec_ignored");

        // Snapshot and hour editing with 23->0 wrap
        eh = 12; em = 34; es = 56;
        cyc(1, 0, 0, mk(tm(eh, em, es), 0, 3'b100, 1), "load");
        for (int k = 0; k < 13; k++) begin
            eh = (eh + 1) % 24;
            cyc(0, 1, 0, mk(tm(eh, em, es), 0, 3'b100, 1), "h_inc");
        end
        chk("hour_after_13_inc", 32'(time_set[16:12]), 32'd1);

        cyc(1, 0, 0, mk(tm(eh, em, es), 0, 3'b010, 1), "to_min");
        em = (em + 59) % 60;
        cyc(0, 0, 1, mk(tm(eh, em, es), 0, 3'b010, 1), "m_dec");
        chk("min_after_dec", 32'(time_set[11:6]), 32'd33);
        cyc(0, 1, 1, mk(tm(eh, em, es), 0, 3'b010, 1), "m_inc_dec_same");
        cyc(1, 1, 0, mk(tm(eh, em, es), 0, 3'b001, 1), "m_mode_with_inc");

        for (int k = 0; k < 57; k++) begin
            es = (es + 59) % 60;
            cyc(0, 0, 1, mk(tm(eh, em, es), 0, 3'b001, 1), "s_dec");
        end
        chk("sec_after_57_dec", 32'(time_set[5:0]), 32'd59);

        // Commit: strobe rises on the second edge after the final mode pulse
        cyc(1, 0, 0, mk(tm(eh, em, es), 0, 3'b000, 1), "commit_entry");
        for (int k = 0; k < OWC; k++)
            cyc(0, 1, 0, mk(tm(1, 33, 59), 1, 3'b000, 1), "ow_high");
        cyc(0, 0, 0, mk(tm(1, 33, 59), 0, 3'b000, 0), "ow_end");
        cyc(0, 0, 0, mk(tm(1, 33, 59), 0, 3'b000, 0), "run_holds_commit");

        // Idle timeout from EDIT_M, no overwrite
        time_cur = tm(5, 6, 7);
        cyc(1, 0, 0, mk(tm(5, 6, 7), 0, 3'b100, 1), "to_load");
        cyc(1, 0, 0, mk(tm(5, 6, 7), 0, 3'b010, 1), "to_min");
        for (int k = 1; k < TOC; k++)
            cyc(0, 0, 0, mk(tm(5, 6, 7), 0, 3'b010, 1), "to_idle");
        cyc(0, 0, 0, mk(tm(5, 6, 7), 0, 3'b000, 0), "timeout");
        for (int k = 0; k < 3; k++)
            cyc(0, 0, 0, mk(tm(5, 6, 7), 0, 3'b000, 0), "post_timeout");

        // Reset during the second cycle of COMMIT
        time_cur = tm(10, 20, 30);
        cyc(1, 0, 0, mk(tm(10, 20, 30), 0, 3'b100, 1), "cr_load");
        cyc(1, 0, 0, mk(tm(10, 20, 30), 0, 3'b010, 1), "cr_min");
        cyc(1, 0, 0, mk(tm(10, 20, 30), 0, 3'b001, 1), "cr_sec");
        cyc(1, 0, 0, mk(tm(10, 20, 30), 0, 3'b000, 1), "cr_commit1");
        cyc(0, 0, 0, mk(tm(10, 20, 30), 1, 3'b000, 1), "cr_commit2");
        #1;
        rst = 1'b1;
        #1;
        sb.push_back(mk('0, 0, 3'b000, 0));
        check_out("async_rst_in_commit");
        @(posedge clk_sys);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, mk('0, 0, 3'b000, 0), "post_rst_idle");

        // Out-of-range snapshot clamps, then remaining wrap directions
        time_cur = tm(31, 63, 63);
        cyc(1, 0, 0, mk(tm(0, 0, 0), 0, 3'b100, 1), "clamp_load");
        cyc(0, 1, 0, mk(tm(1, 0, 0), 0, 3'b100, 1), "h_inc");
        cyc(0, 0, 1, mk(tm(0, 0, 0), 0, 3'b100, 1), "h_dec");
        cyc(0, 0, 1, mk(tm(23, 0, 0), 0, 3'b100, 1), "h_dec_wrap");
        cyc(1, 0, 0, mk(tm(23, 0, 0), 0, 3'b010, 1), "to_min");
        cyc(0, 0, 1, mk(tm(23, 59, 0), 0, 3'b010, 1), "m_dec_wrap");
        cyc(0, 1, 0, mk(tm(23, 0, 0), 0, 3'b010, 1), "m_inc_wrap");
        cyc(1, 0, 0, mk(tm(23, 0, 0), 0, 3'b001, 1), "to_sec");
        cyc(0, 1, 0, mk(tm(23, 0, 1), 0, 3'b001, 1), "s_inc");
        cyc(0, 0, 1, mk(tm(23, 0, 0), 0, 3'b001, 1), "s_dec");
        cyc(0, 0, 1, mk(tm(23, 0, 59), 0, 3'b001, 1), "s_dec_wrap");
        cyc(0, 1, 0, mk(tm(23, 0, 0), 0, 3'b001, 1), "s_inc_wrap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Button-driven time-setting controller for the 17-bit hh:mm:ss clock counter (format h[4:0]:m[5:0]:s[5:0]).
- Snapshots the running time, lets the user edit hour, minute and second fields in turn, then commits the edited value.
- Commit drives the counter's time-load bus and its active-high overwrite strobe.
- Runs on the fast system clock, upstream of the 1 Hz counter.

Parameters:
- OW_CYCLES, 4, number of clk_sys cycles the overwrite strobe is held high during commit (1..255).
- TIMEOUT_CYCLES, 1000000, idle clk_sys cycles in an edit state before abandoning the edit (≥2).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- btn_mode  in  1  single-cycle pulse, already debounced; advances the edit field.
- btn_inc  in  1  single-cycle pulse; increments the current field.
- btn_dec  in  1  single-cycle pulse; decrements the current field.
- time_cur  in  17  current time from the clock counter.
- time_set  out  17  edited time, {hour, min, sec}; connects to the counter's time-load input.
- time_ow  out  1  overwrite strobe to the counter.
- edit_field  out  3  one-hot field under edit, for display blinking: [2]=hour, [1]=min, [0]=sec; 000 outside edit.
- busy  out  1  high in any state other than RUN.

Behaviour:
- States: RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT. All outputs are registered.
- Reset, applied asynchronously at any time including mid-edit or mid-commit:
  - state=RUN; edit registers h=0, m=0, s=0; time_set=0; time_ow=0; edit_field=000; busy=0; counters cleared.
  - The edit is discarded and time_ow drops immediately.
- RUN:
  - btn_mode → load h/m/s from time_cur in the same edge, then go to EDIT_H.
  - btn_inc/btn_dec are ignored.
- EDIT_H / EDIT_M / EDIT_S, each editing one field:
  - btn_mode advances EDIT_H→EDIT_M→EDIT_S→COMMIT.
  - btn_mode has priority: an inc/dec pulse in the same cycle as btn_mode is dropped.
  - btn_inc alone: field+1. Wraps hour 23→0 and min/sec 59→0.
  - btn_dec alone: field−1. Wraps hour 0→23 and min/sec 0→59.
  - btn_inc and btn_dec in the same cycle: no change.
  - Snapshotted out-of-range values (hour>23, min/sec>59) are clamped to 0 at load.
- Timeout, per edit state:
  - An idle counter resets on any button pulse and on state entry.
  - On reaching TIMEOUT_CYCLES−1 with no button, go to RUN with no commit: time_ow is never asserted and the edit registers are retained but unused.
- COMMIT:
  - time_set already holds {h,m,s}. It is updated continuously from the edit registers and stays stable throughout COMMIT.
  - time_ow=1 for exactly OW_CYCLES consecutive cycles, starting the first cycle after entering COMMIT.
  - Then time_ow=0 and state returns to RUN in the same edge.
  - All buttons are ignored during COMMIT.
- edit_field: 100/010/001 in EDIT_H/M/S, 000 in RUN and COMMIT.
- busy=1 in all states except RUN.
- Latency: a btn_mode pulse in RUN is reflected in edit_field and busy one cycle later. The EDIT_S btn_mode pulse gives time_ow rising 2 cycles later.
- time_set is unchanged in RUN after a commit, so it holds the last committed value.
- Width rules: hour is 5 bits and min/sec are 6 bits. No arithmetic result wider than its field; wrap is done by explicit compare, not by modulo truncation.

Test Plan:
- Reset, then btn_mode with time_cur=12:34:56 → edit_field=100, busy=1, time_set=12:34:56.
- In EDIT_H, 13× btn_inc from 12 → hour=1 (wrap 23→0). Then btn_mode, btn_dec from min=34 → 33. Then btn_mode, btn_dec×57 from sec=56 → sec=59 (wrap 0→59).
- Full edit, then btn_mode in EDIT_S → time_ow high for exactly 4 cycles (OW_CYCLES=4) with time_set=01:33:59 constant, then busy=0 and edit_field=000.
- btn_mode+btn_inc in the same cycle in EDIT_M → state=EDIT_S, minute unchanged. btn_inc+btn_dec together → no change.
- TIMEOUT_CYCLES=16: enter EDIT_M, no buttons for 16 cycles → RUN, time_ow never asserted.
- rst asserted during the 2nd cycle of COMMIT → time_ow=0 immediately, state=RUN, time_set=0. time_cur=31:63:63 snapshot → fields clamp to 00:00:00.
